// File: rtl/pc_pkg.sv
// Shared defaults, next-PC select encoding and request bundle for the program counter.
// Pure declarations; no state, no timing.
package pc_pkg;

  localparam int ADDR_W_DEF    = 11;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_INC
  } pc_sel_e;

  typedef struct packed {
    logic stall;
    logic ret;
    logic call;
    logic jump;
    logic branch;
  } pc_req_t;

  // A ret on an empty stack or a call on a full stack degrades to a plain increment.
  function automatic pc_sel_e pick_sel(input pc_req_t req, input logic stk_empty,
                                       input logic stk_full);
    pc_sel_e sel;
    sel = SEL_INC;
    if (req.stall)       sel = SEL_HOLD;
    else if (req.ret)    sel = stk_empty ? SEL_INC : SEL_RET;
    else if (req.call)   sel = stk_full  ? SEL_INC : SEL_CALL;
    else if (req.jump)   sel = SEL_JUMP;
    else if (req.branch) sel = SEL_BRANCH;
    return sel;
  endfunction

  function automatic logic stack_fault(input pc_req_t req, input logic stk_empty,
                                       input logic stk_full);
    return !req.stall && ((req.ret && stk_empty) || (!req.ret && req.call && stk_full));
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO: push/pop take effect on the next rising edge, top is combinational.
// No backpressure: push when full and pop when empty are ignored; push+pop replaces the top.
module ras_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_dat,
  output logic [WIDTH-1:0]       top_dat,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             do_push, do_pop;

  assign full    = (depth_q == CNT_W'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign top_idx = PTR_W'(depth_q - CNT_W'(1));
  assign top_dat = mem_q[top_idx];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    depth_d = depth_q;
    mem_d   = mem_q;
    wr_idx  = PTR_W'(depth_q);
    if (do_push && do_pop) begin
      wr_idx        = top_idx;
      mem_d[wr_idx] = push_dat;
    end else if (do_push) begin
      mem_d[wr_idx] = push_dat;
      depth_d       = depth_q + CNT_W'(1);
    end else if (do_pop) begin
      depth_d = depth_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Entry storage is deliberately unreset; it is never observed while depth is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/program_counter.sv
// Program counter with prioritised stall/ret/call/jump/branch/increment and a return-address stack.
// One-edge latency from request to read_PC; stall freezes all state, no other backpressure.
module program_counter
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                RAS_DEPTH  = RAS_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic              call,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              ret,
  output logic [ADDR_W-1:0] read_PC,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int DEPTH_W = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
  logic               err_q, err_d;
  pc_req_t            req;
  pc_sel_e            sel;
  logic               stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0]  stk_top;
  logic [DEPTH_W-1:0] stk_depth;

  ras_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (pc_inc),
    .top_dat  (stk_top),
    .depth    (stk_depth),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_comb begin
    req      = '{stall: stall, ret: ret, call: call, jump: jump, branch: branch};
    sel      = pick_sel(req, stk_empty, stk_full);
    pc_inc   = pc_q + ADDR_W'(1);
    stk_push = (sel == SEL_CALL);
    stk_pop  = (sel == SEL_RET);
    err_d    = err_q | stack_fault(req, stk_empty, stk_full);
    pc_d     = pc_inc;
    case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_RET:    pc_d = stk_top;
      SEL_CALL:   pc_d = jump_target;
      SEL_JUMP:   pc_d = jump_target;
      SEL_BRANCH: pc_d = branch_target;
      default:    pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_ADDR;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign read_PC   = pc_q;
  assign ras_empty = stk_empty;
  assign ras_full  = stk_full;
  assign ras_err   = err_q;

  a_depth_bounded: assert property (@(posedge CLK) disable iff (!RST_N)
    stk_depth <= DEPTH_W'(RAS_DEPTH));

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table, hand-written reset/stall sequences,
// then random traffic against a queue-based reference model.
module tb_program_counter;

  localparam int AW  = 11;
  localparam int DEP = 4;
  localparam int MOD = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          stall, branch, jump, call, ret;
  logic [AW-1:0] branch_target, jump_target;
  logic [AW-1:0] read_PC;
  logic          ras_empty, ras_full, ras_err;

  int n_cmp = 0;
  int n_bad = 0;

  program_counter #(.ADDR_W(AW), .RAS_DEPTH(DEP), .RESET_ADDR('0)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .jump_target   (jump_target),
    .ret           (ret),
    .read_PC       (read_PC),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  typedef struct {
    bit s, r, c, j, b;
    int bt, jt;
    int e_pc;
    bit e_empty, e_full, e_err;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t v(bit s, bit r, bit c, bit j, bit b, int bt, int jt,
                             int e_pc, bit e_empty, bit e_full, bit e_err);
    vec_t x;
    x.s = s; x.r = r; x.c = c; x.j = j; x.b = b; x.bt = bt; x.jt = jt;
    x.e_pc = e_pc; x.e_empty = e_empty; x.e_full = e_full; x.e_err = e_err;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pc, input bit e_empty,
                         input bit e_full, input bit e_err);
    chk({tag, ".pc"},    int'(read_PC),   e_pc);
    chk({tag, ".empty"}, int'(ras_empty), int'(e_empty));
    chk({tag, ".full"},  int'(ras_full),  int'(e_full));
    chk({tag, ".err"},   int'(ras_err),   int'(e_err));
  endtask

  // Drive one request, let one rising edge take it, return 1ns after that edge.
  task automatic step(input bit s, input bit r, input bit c, input bit j, input bit b,
                      input int bt, input int jt);
    stall = s; ret = r; call = c; jump = j; branch = b;
    branch_target = AW'(bt); jump_target = AW'(jt);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; ret = 0; call = 0; jump = 0; branch = 0;
    branch_target = '0; jump_target = '0;
  endtask

  // Called 1ns after a rising edge: pulses reset between edges and checks it took effect at once.
  task automatic reset_pulse(input string tag);
    #2 RST_N = 1'b0;
    #1 chk_all(tag, 0, 1, 0, 0);
    idle_inputs();
    #2 RST_N = 1'b1;
  endtask

  initial begin
    int mpc;
    bit merr;
    int stk[$];
    bit s, r, c, j, b;
    int bt, jt;

    idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk_all("reset", 0, 1, 0, 0);
    RST_N = 1'b1;

    for (int i = 0; i < 5; i++) tbl[i] = v(0,0,0,0,0, 0,0, i + 1, 1,0,0);
    tbl[5]  = v(0,0,0,1,0, 0,     'h7FF, 'h7FF, 1,0,0);
    tbl[6]  = v(0,0,0,0,0, 0,     0,     'h000, 1,0,0);
    tbl[7]  = v(0,0,0,1,0, 0,     'h010, 'h010, 1,0,0);
    tbl[8]  = v(0,0,1,0,0, 0,     'h200, 'h200, 0,0,0);
    tbl[9]  = v(0,1,0,0,0, 0,     0,     'h011, 1,0,0);
    tbl[10] = v(0,0,0,1,1, 'h300, 'h100, 'h100, 1,0,0);
    tbl[11] = v(0,0,0,0,1, 'h300, 0,     'h300, 1,0,0);
    tbl[12] = v(0,0,1,0,1, 'h123, 'h400, 'h400, 0,0,0);
    tbl[13] = v(0,0,1,0,0, 0,     'h410, 'h410, 0,0,0);
    tbl[14] = v(0,0,1,0,0, 0,     'h420, 'h420, 0,0,0);
    tbl[15] = v(0,0,1,0,0, 0,     'h430, 'h430, 0,1,0);
    tbl[16] = v(0,0,1,0,0, 0,     'h440, 'h431, 0,1,1);
    tbl[17] = v(0,1,1,0,0, 0,     'h555, 'h421, 0,0,1);
    tbl[18] = v(0,1,0,0,0, 0,     0,     'h411, 0,0,1);
    tbl[19] = v(0,1,0,0,0, 0,     0,     'h401, 0,0,1);
    tbl[20] = v(0,1,0,0,0, 0,     0,     'h301, 1,0,1);
    tbl[21] = v(1,0,1,0,1, 'h111, 'h222, 'h301, 1,0,1);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].j, tbl[i].b, tbl[i].bt, tbl[i].jt);
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_err);
    end

    // Stall with call+branch pending must not touch PC or the stack.
    reset_pulse("rst_a");
    step(0,0,1,0,0, 0, 'h050);     chk_all("call50", 'h050, 0, 0, 0);
    step(1,0,1,0,1, 'h123, 'h321); chk_all("stall50", 'h050, 0, 0, 0);
    step(0,1,0,0,0, 0, 0);         chk_all("ret_after_stall", 'h001, 1, 0, 0);

    // Underflow is sticky until reset.
    step(0,0,0,1,0, 0, 'h020);     chk_all("jmp20", 'h020, 1, 0, 0);
    step(0,1,0,0,0, 0, 0);         chk_all("ret_empty", 'h021, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0,0, 0, 0);
      chk_all($sformatf("sticky%0d", i), 'h022 + i, 1, 0, 1);
    end

    // Reset in the middle of a cycle with requests pending aborts them.
    stall = 1; call = 1; branch = 1; jump_target = AW'('h3AA);
    reset_pulse("rst_mid");
    step(0,0,0,0,0, 0, 0);         chk_all("post_rst", 'h001, 1, 0, 0);

    // Random traffic against the reference model.
    reset_pulse("rst_rand");
    mpc = 0; merr = 0; stk.delete();
    for (int n = 0; n < 3000; n++) begin
      s  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 3) == 0);
      bt = $urandom_range(0, MOD - 1);
      jt = ($urandom_range(0, 7) == 0) ? MOD - 1 : $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 499) == 0) begin
        step(0,0,0,0,0, 0, 0);
        chk("rand.pc", int'(read_PC), (mpc + 1) % MOD);
        reset_pulse("rand_rst");
        mpc = 0; merr = 0; stk.delete();
        continue;
      end
      if (s) begin
      end else if (r) begin
        if (stk.size() == 0) begin mpc = (mpc + 1) % MOD; merr = 1; end
        else mpc = stk.pop_back();
      end else if (c) begin
        if (stk.size() == DEP) begin mpc = (mpc + 1) % MOD; merr = 1; end
        else begin stk.push_back((mpc + 1) % MOD); mpc = jt; end
      end else if (j) mpc = jt;
      else if (b) mpc = bt;
      else mpc = (mpc + 1) % MOD;
      step(s, r, c, j, b, bt, jt);
      chk_all("rand", mpc, stk.size() == 0, stk.size() == DEP, merr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter ADDR_W, default 11, program address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-003 Parameter RESET_ADDR, default 0, PC value loaded on reset.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 stall  in  1  hold PC and stack unchanged this cycle.
REQ-007 branch  in  1  conditional branch taken; load branch_target.
REQ-008 branch_target  in  ADDR_W  branch destination.
REQ-009 jump  in  1  unconditional jump; load jump_target.
REQ-010 call  in  1  push PC+1 onto stack, load jump_target.
REQ-011 jump_target  in  ADDR_W  jump/call destination.
REQ-012 ret  in  1  pop stack top into PC.
REQ-013 read_PC  out  ADDR_W  current program counter, registered.
REQ-014 ras_empty  out  1  stack holds zero entries.
REQ-015 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-016 ras_err  out  1  sticky flag: overflow or underflow occurred.

Function
REQ-017 Next-PC priority, one action per cycle: stall > ret > call > jump > branch > increment.
REQ-018 Increment: read_PC <= read_PC + 1, modulo 2^ADDR_W (max address wraps to 0, no flag).
REQ-019 Latency: the selected next-PC appears on read_PC one rising edge after the request; requests are sampled only at that edge.
REQ-020 call with stack not full: push (read_PC + 1) mod 2^ADDR_W, read_PC <= jump_target, depth +1.
REQ-021 call with ras_full: no push, read_PC <= read_PC + 1, ras_err <= 1.
REQ-022 ret with stack not empty: read_PC <= top entry, depth -1.
REQ-023 ret with ras_empty: no pop, read_PC <= read_PC + 1, ras_err <= 1.
REQ-024 Lower-priority requests asserted together with a higher one are discarded, not queued.
REQ-025 stall: read_PC, stack contents, depth and ras_err all hold, regardless of other inputs.
REQ-026 ras_empty/ras_full combinational from the registered depth count (0..RAS_DEPTH, width clog2(RAS_DEPTH)+1).
REQ-027 ras_err clears only on reset.

Reset
REQ-028 RST_N low asynchronously forces read_PC = RESET_ADDR, depth = 0, ras_err = 0, ras_empty = 1, ras_full = 0.
REQ-029 Stack entry contents are not reset; they are unreadable while depth = 0.
REQ-030 Reset asserted mid-call/ret aborts the operation; the first post-reset edge with RST_N high performs the normal increment.

Structure
REQ-031 Shared package pc_pkg holds ADDR_W/RAS_DEPTH defaults and the next-PC select enum (SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_INC).
REQ-032 One sub-module, ras_stack: LIFO with push/pop/top/depth/full/empty, parametrised by width and depth, async active-low reset on the depth pointer only.
REQ-033 program_counter contains the priority selector, PC register, and error flag only.

Verification
REQ-034 Reset release, 5 idle edges -> read_PC 0,1,2,3,4,5 (ADDR_W=11).
REQ-035 read_PC=0x7FF, no request -> next read_PC=0x000, ras_err=0.
REQ-036 read_PC=0x010, call target 0x200; next edge ret -> read_PC 0x200 then 0x011; ras_empty 1->0->1.
REQ-037 Five nested calls with RAS_DEPTH=4 -> fifth call increments PC, ras_full=1, ras_err=1; four rets unwind in LIFO order.
REQ-038 ret on empty stack at read_PC=0x020 -> read_PC=0x021, ras_err=1, stays 1 until RST_N low.
REQ-039 stall with call+branch asserted at read_PC=0x050 -> read_PC stays 0x050, depth unchanged; RST_N pulsed low mid-cycle -> read_PC=RESET_ADDR immediately.
